// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera stream transmitter.
// Optional build macro: CAM_TX_SCROLL_EN (scrolling colour bars).
package cam_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam int H_ACTIVE_DEF    = 320;
  localparam int V_ACTIVE_DEF    = 240;
  localparam int H_BLANK_DEF     = 144;
  localparam int VSYNC_LINES_DEF = 3;
  localparam int VBP_LINES_DEF   = 17;
  localparam int VFP_LINES_DEF   = 10;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_tx_pattern.sv
// Colour-bar pixel generator with a registered RGB565 output.
// CAM_TX_SCROLL_EN adds frame_cnt to x so the bars move left one pixel per frame.
module cam_tx_pattern
  import cam_tx_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int XW       = $clog2(H_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [XW-1:0] x_i,
  input  logic [7:0]    frame_cnt_i,
  output logic [15:0]   pix_o
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [15:0] pix_q;
  logic [2:0]  bar;
  int          xs;
  int          idx;

`ifdef CAM_TX_SCROLL_EN
  always_comb xs = (int'(x_i) + int'(frame_cnt_i)) % H_ACTIVE;
`else
  logic unused_fc;
  assign unused_fc = ^frame_cnt_i;
  always_comb xs = int'(x_i);
`endif

  // Leftover pixels when H_ACTIVE is not a multiple of 8 fall into the last bar.
  always_comb begin
    idx = xs / BAR_W;
    bar = (idx > 7) ? 3'd7 : 3'(idx);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)     pix_q <= 16'h0000;
    else if (load_i) pix_q <= bar_color(bar);
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/cam_stream_tx.sv
// OV-style camera byte-stream transmitter: pclk = clk/2, href/vsync/data change on pclk falls.
// Optional build macro: CAM_TX_SCROLL_EN (see cam_tx_pattern).
module cam_stream_tx
  import cam_tx_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int H_BLANK     = H_BLANK_DEF,
  parameter int VSYNC_LINES = VSYNC_LINES_DEF,
  parameter int VBP_LINES   = VBP_LINES_DEF,
  parameter int VFP_LINES   = VFP_LINES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pclk,
  output logic       href,
  output logic       vsync,
  output logic [7:0] data,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int HW    = $clog2(LINE);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int MAX_A = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_B = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW    = $clog2(MAXL + 1);

  localparam logic [HW-1:0] LAST_SLOT  = HW'(LINE - 1);
  localparam logic [HW-1:0] HREF_SLOTS = HW'(2 * H_ACTIVE);

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d, last_line;
  logic          pclk_q, href_q, vsync_q, frame_done_q, busy_q;
  logic [7:0]    data_q, frame_cnt_q;
  logic          href_d, last_vfp_d;
  logic [15:0]   pix;

  always_comb begin
    unique case (state_q)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBP:    last_line = LW'(VBP_LINES - 1);
      ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      ST_VFP:    last_line = LW'(VFP_LINES - 1);
      default:   last_line = '0;
    endcase
  end

  // Next slot position; only committed on update cycles (pclk 1->0).
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_VSYNC;
        hcnt_d  = '0;
        lcnt_d  = '0;
      end
    end else if (hcnt_q == LAST_SLOT) begin
      hcnt_d = '0;
      if (lcnt_q == last_line) begin
        lcnt_d = '0;
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          default:   state_d = enable ? ST_VSYNC : ST_IDLE;
        endcase
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
    href_d     = (state_d == ST_ACTIVE) && (hcnt_d < HREF_SLOTS);
    last_vfp_d = (state_d == ST_VFP) && (lcnt_d == LW'(VFP_LINES - 1)) && (hcnt_d == LAST_SLOT);
  end

  // Pixel fetched on the mid-slot edge so it is ready when the high byte goes out.
  cam_tx_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (~pclk_q),
    .x_i         (hcnt_d[XW:1]),
    .frame_cnt_i (frame_cnt_q),
    .pix_o       (pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      pclk_q       <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= 8'h00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      pclk_q       <= ~pclk_q;
      frame_done_q <= 1'b0;
      if (pclk_q) begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        lcnt_q  <= lcnt_d;
        vsync_q <= (state_d == ST_VSYNC);
        href_q  <= href_d;
        data_q  <= href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        busy_q  <= (state_d != ST_IDLE);
        if (last_vfp_d) begin
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  assign pclk       = pclk_q;
  assign href       = href_q;
  assign vsync      = vsync_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx on a shrunken frame geometry; frame-position model plus pixel tables.
module tb_cam_stream_tx;

  localparam int H    = 16;
  localparam int V    = 6;
  localparam int HB   = 8;
  localparam int VS   = 2;
  localparam int VB   = 2;
  localparam int VF   = 2;
  localparam int LINE = 2 * H + HB;
  localparam int FRAME = LINE * (VS + VB + V + VF);
  localparam int ACT0 = VS + VB;

  logic       clk, reset, enable;
  logic       pclk, href, vsync, frame_done, busy;
  logic [7:0] data, frame_cnt;

  cam_stream_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
    .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pclk(pclk), .href(href),
    .vsync(vsync), .data(data), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;
    logic       done;
    logic [7:0] fc;
    logic       busy;
  } outs_t;

  typedef struct {
    int         frame;
    int         col;
    logic       href;
    logic [7:0] data;
  } vec_t;

  int checks = 0, failures = 0, nprint = 0;
  int n_done = 0, n_vs = 0;

  // Reference: position within a frame as a single slot index.
  bit         m_pclk = 0, m_busy = 0, m_done = 0;
  int         m_slot = 0, m_frame = 0;
  logic [7:0] m_fc = 0;
  logic [8:0] cap [2][LINE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int off);
    case (((x + off) % H) / (H / 8))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    int ln, col, off;
    logic [15:0] px;
    o = '0;
    o.pclk = m_pclk;
    o.done = m_done;
    o.fc   = m_fc;
    o.busy = m_busy;
`ifdef CAM_TX_SCROLL_EN
    off = int'(m_fc);
`else
    off = 0;
`endif
    if (m_busy) begin
      ln  = m_slot / LINE;
      col = m_slot % LINE;
      o.vsync = (ln < VS);
      if (ln >= ACT0 && ln < ACT0 + V && col < 2 * H) begin
        o.href = 1'b1;
        px = pix(col / 2, off);
        o.data = (col % 2 == 1) ? px[7:0] : px[15:8];
      end
    end
    return o;
  endfunction

  task automatic tick();
    logic rst_s, en_s;
    bit upd;
    outs_t act, exp;
    rst_s = reset;
    en_s  = enable;
    upd   = 0;
    @(posedge clk);
    #1;
    if (rst_s) begin
      m_pclk = 0; m_busy = 0; m_slot = 0; m_fc = 0; m_done = 0;
    end else begin
      upd = m_pclk;
      m_pclk = ~m_pclk;
      m_done = 0;
      if (upd) begin
        if (!m_busy) begin
          if (en_s) begin m_busy = 1; m_slot = 0; m_frame++; end
        end else if (m_slot == FRAME - 1) begin
          if (en_s) begin m_slot = 0; m_frame++; end
          else m_busy = 0;
        end else begin
          m_slot++;
          if (m_slot == FRAME - 1) begin m_done = 1; m_fc++; end
        end
      end
    end
    exp = model_out();
    act = {pclk, href, vsync, data, frame_done, frame_cnt, busy};
    check("outputs", 32'(act), 32'(exp));
    if (frame_done) n_done++;
    if (vsync) n_vs++;
    if (upd && m_busy && m_frame >= 1 && m_frame <= 2 && m_slot / LINE == ACT0)
      cap[m_frame-1][m_slot % LINE] = {href, data};
  endtask

  vec_t tbl[$];

  initial begin
    int guard, quiet;
    bit seen;
    logic [15:0] f1p0, f1p1;

    for (int f = 0; f < 2; f++)
      for (int c = 0; c < LINE; c++) cap[f][c] = 9'h1FF;

    // First active line of frame 0: one pixel from each bar, the last pixel, and the blanking.
    tbl.push_back('{0, 0,  1'b1, 8'hFF}); tbl.push_back('{0, 1,  1'b1, 8'hFF});
    tbl.push_back('{0, 4,  1'b1, 8'hFF}); tbl.push_back('{0, 5,  1'b1, 8'hE0});
    tbl.push_back('{0, 8,  1'b1, 8'h07}); tbl.push_back('{0, 9,  1'b1, 8'hFF});
    tbl.push_back('{0, 12, 1'b1, 8'h07}); tbl.push_back('{0, 13, 1'b1, 8'hE0});
    tbl.push_back('{0, 16, 1'b1, 8'hF8}); tbl.push_back('{0, 17, 1'b1, 8'h1F});
    tbl.push_back('{0, 20, 1'b1, 8'hF8}); tbl.push_back('{0, 21, 1'b1, 8'h00});
    tbl.push_back('{0, 24, 1'b1, 8'h00}); tbl.push_back('{0, 25, 1'b1, 8'h1F});
    tbl.push_back('{0, 30, 1'b1, 8'h00}); tbl.push_back('{0, 31, 1'b1, 8'h00});
    tbl.push_back('{0, 32, 1'b0, 8'h00}); tbl.push_back('{0, 39, 1'b0, 8'h00});
`ifdef CAM_TX_SCROLL_EN
    f1p0 = 16'hFFFF; f1p1 = 16'hFFE0;
`else
    f1p0 = 16'hFFFF; f1p1 = 16'hFFFF;
`endif
    tbl.push_back('{1, 0, 1'b1, f1p0[15:8]}); tbl.push_back('{1, 1, 1'b1, f1p0[7:0]});
    tbl.push_back('{1, 2, 1'b1, f1p1[15:8]}); tbl.push_back('{1, 3, 1'b1, f1p1[7:0]});

    reset = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("pclk_first_high", 32'(pclk), 32'd1);
    repeat (9) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Two back-to-back frames.
    enable = 1'b1;
    n_vs = 0; n_done = 0;
    guard = 0;
    while (n_done < 1 && guard < 2 * FRAME + 20) begin tick(); guard++; end
    check("frame0_done_seen", 32'(n_done), 32'd1);
    check("vsync_clk_len", 32'(n_vs), 32'(2 * VS * LINE));
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);
    check("vsync_low_last_slot", 32'(vsync), 32'd0);
    tick(); tick();
    check("vsync_next_update", 32'(vsync), 32'd1);
    guard = 0;
    while (n_done < 2 && guard < 2 * FRAME + 20) begin tick(); guard++; end
    check("frame1_done_count", 32'(n_done), 32'd2);
    check("frame_cnt_2", 32'(frame_cnt), 32'd2);

    foreach (tbl[i])
      check($sformatf("pix_f%0d_b%0d", tbl[i].frame, tbl[i].col),
            32'(cap[tbl[i].frame][tbl[i].col]), 32'({tbl[i].href, tbl[i].data}));

    // Enable dropped mid-active: the frame still finishes, then idle.
    guard = 0;
    while (!(m_busy && m_slot / LINE == ACT0 + 3) && guard < 2 * FRAME + 20) begin tick(); guard++; end
    check("reach_active_line3", 32'(m_slot / LINE), 32'(ACT0 + 3));
    enable = 1'b0;
    n_done = 0;
    guard = 0;
    while (m_busy && guard < 2 * FRAME + 20) begin tick(); guard++; end
    tick();
    check("drop_done_count", 32'(n_done), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    quiet = 0;
    repeat (100) begin
      tick();
      if (vsync || href || data != 8'h00 || busy) quiet++;
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // Reset in the middle of an active line.
    enable = 1'b1;
    guard = 0;
    while (!(m_busy && m_slot / LINE == ACT0 + 1 && m_slot % LINE == 7) && guard < 2 * FRAME + 20) begin
      tick(); guard++;
    end
    check("reach_active_line1", 32'(m_slot / LINE), 32'(ACT0 + 1));
    reset = 1'b1;
    tick();
    check("rst_zero", 32'({pclk, href, vsync, data, frame_done, frame_cnt, busy}), 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    n_vs = 0;
    repeat (60) tick();
    check("no_vsync_without_en", 32'(n_vs), 32'd0);
    enable = 1'b1;
    seen = 0;
    guard = 0;
    while (!seen && guard < 6) begin tick(); guard++; seen = vsync; end
    check("vsync_after_en", 32'(seen), 32'd1);

    // Random enable toggles and occasional resets against the model.
    repeat (4000) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
